zeroheti_obi_arbiter: RTL and testbench
=======================================

# zeroheti_obi_arbiter

N-to-1 OBI arbiter that shares a single OBI subordinate (an SRAM bank or the OBI-to-APB bridge) between several OBI managers: debug system-bus access, Ibex instruction fetch and Ibex data. It sits between the managers and one crossbar subordinate port. It selects one request per cycle, forwards it with zero added latency, tracks the single outstanding transaction, and routes the response back to its owner. Port 0 optionally has fixed top priority; the other ports are round-robin.

## Interface
- `NumReq`, 3: number of manager ports (2..8).
- `AddrWidth`, 32: address width.
- `DataWidth`, 32: data width; byte enable is `DataWidth/8`.
- `Port0Prio`, 1: 1 = port 0 always wins when requesting; 0 = port 0 joins the round-robin.
- One clock; reset is asynchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `req_i` in NumReq: per-manager request.
- `addr_i` in NumReq x AddrWidth: per-manager address.
- `we_i` in NumReq: per-manager write enable.
- `be_i` in NumReq x DataWidth/8: per-manager byte enables.
- `wdata_i` in NumReq x DataWidth: per-manager write data.
- `gnt_o` out NumReq: per-manager grant.
- `rvalid_o` out NumReq: per-manager response valid.
- `rdata_o` out DataWidth: response data, broadcast to all managers.
- `err_o` out 1: response error, broadcast; only meaningful with `rvalid_o`.
- `sbr_req_o`, `sbr_addr_o`, `sbr_we_o`, `sbr_be_o`, `sbr_wdata_o` out: request to the subordinate.
- `sbr_gnt_i`, `sbr_rvalid_i` in 1: subordinate grant and response valid.
- `sbr_rdata_i` in DataWidth, `sbr_err_i` in 1: subordinate response.
- `proto_err_o` out 1: sticky flag; set by `sbr_rvalid_i` arriving with no transaction outstanding.

## Operation
- State registers:
  - `busy`: one transaction outstanding.
  - `owner` ($clog2(NumReq) bits): manager that owns the outstanding transaction.
  - `lock` and `lock_idx`: request presented but not yet granted.
  - `rr_ptr`: round-robin pointer.
- Request may issue when `!busy`, or when `busy && sbr_rvalid_i` (back-to-back issue in the response cycle).
- Winner selection:
  - `lock` set: winner = `lock_idx`, even if higher-priority requests have arrived.
  - Else, `Port0Prio=1` and `req_i[0]`: winner = 0.
  - Else: the first requesting index at or after `rr_ptr`, searched cyclically.
- When a request may issue and a winner exists:
  - `sbr_req_o=1`; `sbr_*` fields are the winner's fields.
  - `gnt_o[winner]=sbr_gnt_i`; every other `gnt_o` bit is 0.
- When no request may issue: `sbr_req_o=0`, all `gnt_o=0`, and `sbr_*` fields are held at 0.
- Handshake (`sbr_req_o && sbr_gnt_i`):
  - `busy<=1`, `owner<=winner`, `lock<=0`.
  - `rr_ptr<=(winner+1) mod NumReq`, except when `Port0Prio=1` and winner=0, where `rr_ptr` is unchanged.
- `sbr_req_o && !sbr_gnt_i`: `lock<=1`, `lock_idx<=winner`. This keeps OBI request stability.
- Response:
  - `rvalid_o[owner]=sbr_rvalid_i && busy`.
  - `rdata_o=sbr_rdata_i`, `err_o=sbr_err_i`.
  - On `sbr_rvalid_i`, `busy<=0`, unless a handshake occurs in the same cycle, in which case `busy` stays 1 with the new `owner`.
- `sbr_rvalid_i && !busy`: response is dropped, all `rvalid_o=0`, `proto_err_o<=1`. The flag clears only on reset.
- A manager that deasserts `req_i` while locked violates OBI. The arbiter holds `lock_idx` regardless, and clears `lock` when that `req_i` is low.
- Reset (any time, including mid-transaction): `busy=0`, `owner=0`, `lock=0`, `rr_ptr=0`, `proto_err_o=0`.
  - All outputs are 0 while `rst_i` is high.
  - An outstanding response arriving after reset is treated as spurious and sets `proto_err_o`.

## Timing
- Request path `req_i` -> `sbr_req_o` and grant path `sbr_gnt_i` -> `gnt_o` are combinational: 0 cycles added.
- Response path `sbr_rvalid_i` -> `rvalid_o` is combinational, routed by the registered `owner`: 0 cycles added.
- Throughput: one transaction per cycle with a single-cycle subordinate (grant in cycle N, rvalid in N+1 together with the next grant).
- There is no combinational path from `sbr_gnt_i` to winner selection. Winner selection depends only on `req_i` and registered state.
- All state updates happen on the rising edge of `clk_i`.

## Test plan
- Single port, `NumReq=3`: `req_i=3'b100`, `addr_i[2]=0x0001_0040`, subordinate grants immediately with rvalid 1 cycle later and `rdata=0xDEADBEEF` -> `sbr_addr_o=0x0001_0040`, `gnt_o=3'b100` same cycle, `rvalid_o=3'b100` with `rdata_o=0xDEADBEEF` next cycle, `busy` back to 0.
- Round-robin, `Port0Prio=0`, `req_i=3'b111` held for 6 transactions -> grant order 0,1,2,0,1,2.
- Priority, `Port0Prio=1`: ports 1 and 2 request continuously while port 0 requests every third cycle -> port 0 wins whenever `req_i[0]`; ports 1 and 2 alternate otherwise.
- Lock: port 1 presented with `sbr_gnt_i=0` for 3 cycles, port 0 asserts in cycle 2 -> `sbr_addr_o` stays at port 1's address until grant; port 0 is served only after that.
- Back-to-back: subordinate asserts `sbr_rvalid_i` and `sbr_gnt_i` in the same cycle -> `rvalid_o` goes to the old owner, `gnt_o` to the new winner, `busy` stays 1, `owner` updates.
- Spurious and reset: `sbr_rvalid_i=1` while idle -> all `rvalid_o=0`, `proto_err_o=1` sticky. Assert `rst_i` mid-transaction -> all outputs 0 immediately and `proto_err_o=0`.

Source files
------------

// File: rtl/zeroheti_obi_arbiter.sv
// N-to-1 OBI arbiter: shares one OBI subordinate between several managers.
// Zero-latency request/grant/response forwarding, one outstanding transaction,
// optional fixed priority for port 0, round-robin for the rest.
module zeroheti_obi_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter bit          Port0Prio = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_i,
  input  logic [NumReq*AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0]               we_i,
  input  logic [NumReq*(DataWidth/8)-1:0] be_i,
  input  logic [NumReq*DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]               gnt_o,
  output logic [NumReq-1:0]               rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            err_o,
  output logic                            sbr_req_o,
  output logic [AddrWidth-1:0]            sbr_addr_o,
  output logic                            sbr_we_o,
  output logic [DataWidth/8-1:0]          sbr_be_o,
  output logic [DataWidth-1:0]            sbr_wdata_o,
  input  logic                            sbr_gnt_i,
  input  logic                            sbr_rvalid_i,
  input  logic [DataWidth-1:0]            sbr_rdata_i,
  input  logic                            sbr_err_i,
  output logic                            proto_err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BeW  = DataWidth / 8;

  logic            busy_q, busy_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic            proto_err_q, proto_err_d;

  logic            can_issue;
  logic            lock_vld;
  logic            win_vld;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;

  // A new request may go out when idle or in the cycle the pending response returns.
  assign can_issue   = !busy_q || sbr_rvalid_i;
  assign proto_err_o = proto_err_q;

  // Winner selection: depends only on req_i and registered state, never on sbr_gnt_i.
  always_comb begin
    lock_vld = lock_q & req_i[lock_idx_q];
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    if (lock_vld) begin
      win_vld = 1'b1;
      win_idx = lock_idx_q;
    end else if (Port0Prio && req_i[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = IdxW'((32'(rr_q) + k) % NumReq);
        if (!win_vld && req_i[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  // Request mux, grant and response routing; all outputs forced low during reset.
  always_comb begin
    sbr_req_o   = 1'b0;
    sbr_addr_o  = '0;
    sbr_we_o    = 1'b0;
    sbr_be_o    = '0;
    sbr_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    err_o       = 1'b0;
    if (!rst_i) begin
      if (can_issue && win_vld) begin
        sbr_req_o      = 1'b1;
        sbr_addr_o     = addr_i[win_idx*AddrWidth +: AddrWidth];
        sbr_we_o       = we_i[win_idx];
        sbr_be_o       = be_i[win_idx*BeW +: BeW];
        sbr_wdata_o    = wdata_i[win_idx*DataWidth +: DataWidth];
        gnt_o[win_idx] = sbr_gnt_i;
      end
      // A response with nothing outstanding is dropped here.
      if (busy_q) begin
        rvalid_o[owner_q] = sbr_rvalid_i;
      end
      rdata_o = sbr_rdata_i;
      err_o   = sbr_err_i;
    end
  end

  // Next-state for transaction tracking, request lock and round-robin pointer.
  always_comb begin
    busy_d      = busy_q;
    owner_d     = owner_q;
    lock_d      = lock_vld;  // a manager dropping req while locked releases the lock
    lock_idx_d  = lock_idx_q;
    rr_d        = rr_q;
    proto_err_d = proto_err_q | (sbr_rvalid_i & ~busy_q);
    if (sbr_rvalid_i) begin
      busy_d = 1'b0;
    end
    if (sbr_req_o) begin
      if (sbr_gnt_i) begin
        busy_d  = 1'b1;
        owner_d = win_idx;
        lock_d  = 1'b0;
        // Port 0 wins under fixed priority do not move the round-robin pointer.
        if (!(Port0Prio && (win_idx == '0))) begin
          rr_d = IdxW'((32'(win_idx) + 32'd1) % NumReq);
        end
      end else begin
        // Keep the presented request stable until it is granted.
        lock_d     = 1'b1;
        lock_idx_d = win_idx;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q      <= 1'b0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      rr_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      rr_q        <= rr_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
// Bench for zeroheti_obi_arbiter: two instances (port-0 priority on/off) driven
// independently, checked every cycle against a transaction-level model, plus
// directed scenarios with hand-computed expectations.
module tb_zeroheti_obi_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: Port0Prio=1, index 1: Port0Prio=0.
  logic [N-1:0]    req       [2];
  logic [N*AW-1:0] addr      [2];
  logic [N-1:0]    we        [2];
  logic [N*BW-1:0] be        [2];
  logic [N*DW-1:0] wdata     [2];
  logic [N-1:0]    gnt       [2];
  logic [N-1:0]    rvalid    [2];
  logic [DW-1:0]   rdata     [2];
  logic            err       [2];
  logic            sbr_req   [2];
  logic [AW-1:0]   sbr_addr  [2];
  logic            sbr_we    [2];
  logic [BW-1:0]   sbr_be    [2];
  logic [DW-1:0]   sbr_wdata [2];
  logic            sbr_gnt   [2];
  logic            sbr_rvalid[2];
  logic [DW-1:0]   sbr_rdata [2];
  logic            sbr_err   [2];
  logic            proto_err [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    zeroheti_obi_arbiter #(
      .NumReq   (N),
      .AddrWidth(AW),
      .DataWidth(DW),
      .Port0Prio(g == 0)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req[g]),
      .addr_i      (addr[g]),
      .we_i        (we[g]),
      .be_i        (be[g]),
      .wdata_i     (wdata[g]),
      .gnt_o       (gnt[g]),
      .rvalid_o    (rvalid[g]),
      .rdata_o     (rdata[g]),
      .err_o       (err[g]),
      .sbr_req_o   (sbr_req[g]),
      .sbr_addr_o  (sbr_addr[g]),
      .sbr_we_o    (sbr_we[g]),
      .sbr_be_o    (sbr_be[g]),
      .sbr_wdata_o (sbr_wdata[g]),
      .sbr_gnt_i   (sbr_gnt[g]),
      .sbr_rvalid_i(sbr_rvalid[g]),
      .sbr_rdata_i (sbr_rdata[g]),
      .sbr_err_i   (sbr_err[g]),
      .proto_err_o (proto_err[g])
    );
  end

  int n_total = 0;
  int n_pass  = 0;

  // Model: outstanding flag/owner, committed (presented, ungranted) manager, rr pointer.
  bit m_busy [2];
  int m_owner[2];
  int m_pend [2];
  int m_rr   [2];
  bit m_perr [2];
  int m_win  [2];

  // Random managers: hold a request with stable fields until granted.
  bit            mact  [2][N];
  logic [AW-1:0] maddr [2][N];
  logic          mwe   [2][N];
  logic [BW-1:0] mbe   [2][N];
  logic [DW-1:0] mwdata[2][N];

  // Lock scenario table (instance 1).
  logic [N-1:0]  lk_req [6] = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b001, 3'b000};
  logic          lk_gnt [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic          lk_rv  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [AW-1:0] lk_addr[6] = '{32'hB000_0004, 32'hB000_0004, 32'hB000_0004, 32'hB000_0004,
                                32'hA000_0000, 32'h0};
  logic [N-1:0]  lk_egnt[6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};
  logic [N-1:0]  lk_erv [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic model_reset(input int d);
    m_busy[d]  = 1'b0;
    m_owner[d] = 0;
    m_pend[d]  = -1;
    m_rr[d]    = 0;
    m_perr[d]  = 1'b0;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      req[d]        = '0;
      addr[d]       = '0;
      we[d]         = '0;
      be[d]         = '0;
      wdata[d]      = '0;
      sbr_gnt[d]    = 1'b0;
      sbr_rvalid[d] = 1'b0;
      sbr_rdata[d]  = '0;
      sbr_err[d]    = 1'b0;
    end
  endtask

  // Compute expected outputs from current inputs and model state; compare all outputs.
  task automatic eval_cmp();
    logic [N-1:0]  e_gnt, e_rv;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wdata, e_rdata;
    logic          e_req, e_we, e_err;
    int            w, idx;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      w = -1;
      if (!rst && (!m_busy[d] || sbr_rvalid[d])) begin
        if (m_pend[d] >= 0 && req[d][m_pend[d]]) w = m_pend[d];
        else if (d == 0 && req[d][0]) w = 0;
        else begin
          for (int k = 0; k < N; k++) begin
            idx = (m_rr[d] + k) % N;
            if (w < 0 && req[d][idx]) w = idx;
          end
        end
      end
      m_win[d] = w;
      e_req = 1'b0; e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
      e_gnt = '0; e_rv = '0; e_rdata = '0; e_err = 1'b0;
      if (!rst) begin
        if (w >= 0) begin
          e_req    = 1'b1;
          e_addr   = addr[d][w*AW +: AW];
          e_we     = we[d][w];
          e_be     = be[d][w*BW +: BW];
          e_wdata  = wdata[d][w*DW +: DW];
          e_gnt[w] = sbr_gnt[d];
        end
        if (m_busy[d] && sbr_rvalid[d]) e_rv[m_owner[d]] = 1'b1;
        e_rdata = sbr_rdata[d];
        e_err   = sbr_err[d];
      end
      chk($sformatf("dut%0d sbr_req", d), sbr_req[d], e_req);
      chk($sformatf("dut%0d sbr_addr", d), sbr_addr[d], e_addr);
      chk($sformatf("dut%0d sbr_we", d), sbr_we[d], e_we);
      chk($sformatf("dut%0d sbr_be", d), sbr_be[d], e_be);
      chk($sformatf("dut%0d sbr_wdata", d), sbr_wdata[d], e_wdata);
      chk($sformatf("dut%0d gnt", d), gnt[d], e_gnt);
      chk($sformatf("dut%0d rvalid", d), rvalid[d], e_rv);
      chk($sformatf("dut%0d rdata", d), rdata[d], e_rdata);
      chk($sformatf("dut%0d err", d), err[d], e_err);
      chk($sformatf("dut%0d proto_err", d), proto_err[d], m_perr[d]);
    end
  endtask

  // Advance the model across the rising edge, then return at the falling edge.
  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_reset(d);
      end else begin
        if (sbr_rvalid[d] && !m_busy[d]) m_perr[d] = 1'b1;
        if (m_pend[d] >= 0 && !req[d][m_pend[d]]) m_pend[d] = -1;
        if (m_win[d] >= 0 && sbr_gnt[d]) begin
          m_busy[d]  = 1'b1;
          m_owner[d] = m_win[d];
          m_pend[d]  = -1;
          if (!(d == 0 && m_win[d] == 0)) m_rr[d] = (m_win[d] + 1) % N;
          mact[d][m_win[d]] = 1'b0;
        end else begin
          if (m_win[d] >= 0) m_pend[d] = m_win[d];
          if (sbr_rvalid[d]) m_busy[d] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    eval_cmp();
    advance();
  endtask

  task automatic drive_random();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < N; p++) begin
        if (rst) mact[d][p] = 1'b0;
        else if (!mact[d][p] && $urandom_range(0, 2) == 0) begin
          mact[d][p]   = 1'b1;
          maddr[d][p]  = $urandom;
          mwe[d][p]    = 1'($urandom_range(0, 1));
          mbe[d][p]    = 4'($urandom);
          mwdata[d][p] = $urandom;
        end
        req[d][p]             = mact[d][p];
        addr[d][p*AW +: AW]   = mact[d][p] ? maddr[d][p] : $urandom;
        we[d][p]              = mact[d][p] ? mwe[d][p] : 1'($urandom_range(0, 1));
        be[d][p*BW +: BW]     = mact[d][p] ? mbe[d][p] : 4'($urandom);
        wdata[d][p*DW +: DW]  = mact[d][p] ? mwdata[d][p] : $urandom;
      end
      sbr_gnt[d]    = ($urandom_range(0, 9) < 6);
      sbr_rvalid[d] = m_busy[d] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
      sbr_rdata[d]  = $urandom;
      sbr_err[d]    = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    logic [N-1:0] eg, er;
    idle();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) model_reset(d);
    @(negedge clk);
    eval_cmp();
    chk("reset gnt", gnt[0], 3'b000);
    chk("reset proto_err", proto_err[1], 1'b0);
    advance();
    rst = 1'b0;

    // Single port on port 2.
    req[0] = 3'b100;
    addr[0][2*AW +: AW] = 32'h0001_0040;
    sbr_gnt[0] = 1'b1;
    eval_cmp();
    chk("single sbr_addr", sbr_addr[0], 32'h0001_0040);
    chk("single gnt", gnt[0], 3'b100);
    advance();
    req[0] = '0; sbr_gnt[0] = 1'b0; sbr_rvalid[0] = 1'b1; sbr_rdata[0] = 32'hDEAD_BEEF;
    eval_cmp();
    chk("single rvalid", rvalid[0], 3'b100);
    chk("single rdata", rdata[0], 32'hDEAD_BEEF);
    advance();
    // Idle again: a new request is presented immediately.
    sbr_rvalid[0] = 1'b0; req[0] = 3'b001;
    eval_cmp();
    chk("idle after response sbr_req", sbr_req[0], 1'b1);
    advance();
    sbr_gnt[0] = 1'b1;
    step();
    req[0] = '0; sbr_gnt[0] = 1'b0; sbr_rvalid[0] = 1'b1;
    step();

    // Round-robin with back-to-back responses on instance 1.
    idle();
    for (int p = 0; p < N; p++) addr[1][p*AW +: AW] = 32'h100 * (p + 1);
    for (int k = 0; k < 6; k++) begin
      req[1] = 3'b111; sbr_gnt[1] = 1'b1; sbr_rvalid[1] = (k > 0);
      eval_cmp();
      eg = '0; eg[k % 3] = 1'b1;
      chk("rr gnt", gnt[1], eg);
      if (k > 0) begin
        er = '0; er[(k - 1) % 3] = 1'b1;
        chk("b2b rvalid", rvalid[1], er);
      end
      advance();
    end
    req[1] = '0; sbr_gnt[1] = 1'b0; sbr_rvalid[1] = 1'b1;
    step();

    // Port-0 priority on instance 0: port 0 requests every third cycle.
    idle();
    for (int k = 0; k < 9; k++) begin
      req[0] = (k % 3 == 0) ? 3'b111 : 3'b110;
      sbr_gnt[0] = 1'b1; sbr_rvalid[0] = (k > 0);
      eval_cmp();
      eg = '0; eg[k % 3] = 1'b1;
      chk("prio gnt", gnt[0], eg);
      advance();
    end
    req[0] = '0; sbr_gnt[0] = 1'b0; sbr_rvalid[0] = 1'b1;
    step();

    // Lock: port 1 held ungranted, port 0 joins later and must wait.
    idle();
    addr[1][0 +: AW]  = 32'hA000_0000;
    addr[1][AW +: AW] = 32'hB000_0004;
    for (int k = 0; k < 6; k++) begin
      req[1] = lk_req[k]; sbr_gnt[1] = lk_gnt[k]; sbr_rvalid[1] = lk_rv[k];
      eval_cmp();
      chk("lock sbr_addr", sbr_addr[1], lk_addr[k]);
      chk("lock gnt", gnt[1], lk_egnt[k]);
      chk("lock rvalid", rvalid[1], lk_erv[k]);
      advance();
    end

    // Spurious response while idle.
    idle();
    sbr_rvalid[1] = 1'b1;
    eval_cmp();
    chk("spurious rvalid", rvalid[1], 3'b000);
    advance();
    sbr_rvalid[1] = 1'b0;
    eval_cmp();
    chk("proto_err set", proto_err[1], 1'b1);
    advance();
    eval_cmp();
    chk("proto_err sticky", proto_err[1], 1'b1);
    advance();

    // Reset in the middle of a transaction on instance 0.
    req[0] = 3'b010; addr[0][AW +: AW] = 32'h0000_1230; sbr_gnt[0] = 1'b1;
    step();
    rst = 1'b1; sbr_rvalid[0] = 1'b1; sbr_rdata[0] = 32'h1234_5678;
    eval_cmp();
    chk("rst sbr_req", sbr_req[0], 1'b0);
    chk("rst gnt", gnt[0], 3'b000);
    chk("rst rvalid", rvalid[0], 3'b000);
    chk("rst rdata", rdata[0], 32'h0);
    chk("rst proto_err", proto_err[1], 1'b0);
    advance();
    rst = 1'b0; req[0] = '0; sbr_gnt[0] = 1'b0;
    eval_cmp();
    chk("late response dropped", rvalid[0], 3'b000);
    advance();
    sbr_rvalid[0] = 1'b0;
    eval_cmp();
    chk("late response proto_err", proto_err[0], 1'b1);
    advance();

    // Randomized traffic with periodic resets.
    for (int c = 0; c < 4000; c++) begin
      rst = (c % 500 >= 497);
      drive_random();
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
